// File: rtl/bsg_manycore_sdr_credit_to_token_pkg.sv
// Shared types and width helpers for the SDR credit-to-token converter.
// Holds the token FSM encoding and the counter/phase sizing functions.
package bsg_manycore_sdr_credit_to_token_pkg;

    typedef enum logic [1:0] {
        e_sdr_token_idle = 2'd0,
        e_sdr_token_high = 2'd1,
        e_sdr_token_low  = 2'd2
    } sdr_token_state_e;

    // Counter must hold a full FIFO's worth of credits, hence one bit over log2 depth.
    function automatic int sdr_cnt_width(input int lg_fifo_depth);
        return lg_fifo_depth + 1;
    endfunction

    function automatic int sdr_phase_width(input int max_cycles);
        return (max_cycles > 1) ? $clog2(max_cycles) : 1;
    endfunction

endpackage

// File: rtl/bsg_manycore_sdr_credit_to_token.sv
// Purpose: batch FIFO dequeue credits into shaped token pulses for one SDR link channel.
// Latency: token_o rises one edge after the count reaches the threshold; min period high+low cycles.
// Backpressure: none; credits accumulate while a pulse is in flight, saturating with a sticky overflow.
module bsg_manycore_sdr_credit_to_token
    import bsg_manycore_sdr_credit_to_token_pkg::*;
#(
    parameter int lg_fifo_depth_p                 = 3,
    parameter int lg_credit_to_token_decimation_p = 2,
    parameter int token_high_cycles_p             = 1,
    parameter int token_low_cycles_p              = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       credit_v_i,
    output logic                       token_o,
    output logic [lg_fifo_depth_p:0]   credits_pending_o,
    output logic                       overflow_o
);

    localparam int cnt_w_lp  = sdr_cnt_width(lg_fifo_depth_p);
    localparam int ph_max_lp = (token_high_cycles_p > token_low_cycles_p)
                             ? token_high_cycles_p : token_low_cycles_p;
    localparam int ph_w_lp   = sdr_phase_width(ph_max_lp);
    localparam logic [cnt_w_lp-1:0] thr_lp = cnt_w_lp'(1 << lg_credit_to_token_decimation_p);
    localparam logic [ph_w_lp-1:0]  high_last_lp = ph_w_lp'(token_high_cycles_p - 1);
    localparam logic [ph_w_lp-1:0]  low_last_lp  = ph_w_lp'(token_low_cycles_p - 1);

    if (lg_credit_to_token_decimation_p > lg_fifo_depth_p) begin : g_bad_decimation
        $error("lg_credit_to_token_decimation_p must not exceed lg_fifo_depth_p");
    end
    if (token_high_cycles_p < 1 || token_low_cycles_p < 1) begin : g_bad_shape
        $error("token_high_cycles_p and token_low_cycles_p must be at least 1");
    end

    sdr_token_state_e      state_r, state_n;
    logic [ph_w_lp-1:0]    ph_r, ph_n;
    logic [cnt_w_lp-1:0]   cnt_r, cnt_n;
    logic                  token_r;
    logic                  overflow_r, overflow_set;
    logic                  launch;
    logic                  cnt_ge_thr;
    logic                  cnt_full;

    assign cnt_ge_thr = (cnt_r >= thr_lp);
    assign cnt_full   = &cnt_r;

    always_comb begin
        state_n = state_r;
        ph_n    = ph_r;
        launch  = 1'b0;
        case (state_r)
            e_sdr_token_idle: begin
                if (cnt_ge_thr) begin
                    launch  = 1'b1;
                    state_n = e_sdr_token_high;
                    ph_n    = '0;
                end
            end
            e_sdr_token_high: begin
                if (ph_r == high_last_lp) begin
                    state_n = e_sdr_token_low;
                    ph_n    = '0;
                end else begin
                    ph_n = ph_r + ph_w_lp'(1);
                end
            end
            e_sdr_token_low: begin
                // Back-to-back tokens skip IDLE so the minimum period stays high+low.
                if (ph_r == low_last_lp) begin
                    ph_n = '0;
                    if (cnt_ge_thr) begin
                        launch  = 1'b1;
                        state_n = e_sdr_token_high;
                    end else begin
                        state_n = e_sdr_token_idle;
                    end
                end else begin
                    ph_n = ph_r + ph_w_lp'(1);
                end
            end
            default: begin
                state_n = e_sdr_token_idle;
                ph_n    = '0;
            end
        endcase
    end

    always_comb begin
        cnt_n        = cnt_r;
        overflow_set = 1'b0;
        if (launch) begin
            cnt_n = cnt_r - thr_lp + cnt_w_lp'(credit_v_i);
        end else if (credit_v_i) begin
            if (cnt_full) begin
                overflow_set = 1'b1;
            end else begin
                cnt_n = cnt_r + cnt_w_lp'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= e_sdr_token_idle;
            ph_r       <= '0;
            cnt_r      <= '0;
            token_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            ph_r       <= ph_n;
            cnt_r      <= cnt_n;
            token_r    <= (state_n == e_sdr_token_high);
            overflow_r <= overflow_r | overflow_set;
        end
    end

    assign token_o           = token_r;
    assign credits_pending_o = cnt_r;
    assign overflow_o        = overflow_r;

endmodule
